// File: rtl/jesd_rx_pkg.sv
// +--------------------------------------------------------------------------+
// | jesd_rx_pkg : shared JESD204B receive-side types and K-character codes    |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

package jesd_rx_pkg;

  // K28.5 comma: HGF=101, EDCBA=11100
  localparam logic [7:0] K28_5 = 8'b101_11100;

  typedef enum logic [1:0] {
    CS_INIT  = 2'd0,
    CS_CHECK = 2'd1,
    CS_DATA  = 2'd2
  } cgs_state_t;

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// +--------------------------------------------------------------------------+
// | sat_counter : up-counter that stops at LIMIT, synchronous clear priority  |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module sat_counter #(
  parameter int WIDTH = 4,
  parameter int LIMIT = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic             at_limit,
  output logic             at_last
);

  localparam logic [WIDTH-1:0] c_limit = WIDTH'(LIMIT);
  localparam logic [WIDTH-1:0] c_last  = WIDTH'(LIMIT - 1);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (inc && (r_count != c_limit)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count    = r_count;
  assign at_limit = (r_count == c_limit);
  // at_last flags that one more increment lands exactly on the limit
  assign at_last  = (r_count == c_last);

endmodule

`default_nettype wire

// File: rtl/jesd_rx_cgs_fsm.sv
// +--------------------------------------------------------------------------+
// | jesd_rx_cgs_fsm : JESD204B lane CGS controller (CS_INIT/CHECK/DATA)       |
// | Optional JESD_CGS_ERR_CNT_EN adds a saturating 16-bit code-error count.   |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module jesd_rx_cgs_fsm
  import jesd_rx_pkg::*;
#(
  parameter int K_CNT_TARGET = 4,
  parameter int INV_LIMIT    = 3,
  parameter int VALID_LIMIT  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        char_valid,
  input  logic [7:0]  char_data,
  input  logic        char_is_k,
  input  logic        char_err,
  input  logic        force_resync,
  output logic        sync_n,
  output logic [1:0]  cgs_state,
  output logic        cgs_done
`ifdef JESD_CGS_ERR_CNT_EN
  ,
  output logic [15:0] err_cnt
`endif
);

  localparam int c_kw = $clog2(K_CNT_TARGET) + 1;
  localparam int c_iw = $clog2(INV_LIMIT) + 1;
  localparam int c_vw = $clog2(VALID_LIMIT) + 1;

  cgs_state_t r_state;
  cgs_state_t w_state_nxt;
  logic       r_sync_n;

  logic [c_kw-1:0] w_kcnt;
  logic [c_iw-1:0] w_icnt;
  logic [c_vw-1:0] w_vcnt;
  logic w_k_last, w_i_last, w_v_last;
  logic w_k_lim, w_i_lim, w_v_lim;
  logic w_k_inc, w_k_clr, w_i_inc, w_i_clr, w_v_inc, w_v_clr;
  logic w_comma_good, w_in_check;

  assign w_comma_good = char_valid && char_is_k && (char_data == K28_5) && !char_err;
  assign w_in_check   = (r_state == CS_CHECK);

  // Counters only exist for the state that owns them; every exit clears them.
  assign w_k_inc = char_valid && (r_state == CS_INIT) && w_comma_good;
  assign w_k_clr = force_resync ||
                   (char_valid && ((r_state != CS_INIT) || !w_comma_good || w_k_last));
  assign w_i_inc = char_valid && char_err && (r_state != CS_INIT);
  assign w_i_clr = force_resync ||
                   (char_valid && w_in_check &&
                    ((char_err && w_i_last) || (!char_err && w_v_last)));
  assign w_v_inc = char_valid && !char_err && w_in_check;
  assign w_v_clr = force_resync || (char_valid && w_in_check && (char_err || w_v_last));

  sat_counter #(.WIDTH(c_kw), .LIMIT(K_CNT_TARGET)) u_kcnt (
    .clk(clk), .rst_n(rst_n), .inc(w_k_inc), .clr(w_k_clr),
    .count(w_kcnt), .at_limit(w_k_lim), .at_last(w_k_last)
  );

  sat_counter #(.WIDTH(c_iw), .LIMIT(INV_LIMIT)) u_icnt (
    .clk(clk), .rst_n(rst_n), .inc(w_i_inc), .clr(w_i_clr),
    .count(w_icnt), .at_limit(w_i_lim), .at_last(w_i_last)
  );

  sat_counter #(.WIDTH(c_vw), .LIMIT(VALID_LIMIT)) u_vcnt (
    .clk(clk), .rst_n(rst_n), .inc(w_v_inc), .clr(w_v_clr),
    .count(w_vcnt), .at_limit(w_v_lim), .at_last(w_v_last)
  );

  // Counter values feed the FSM only through at_last
  logic w_unused;
  assign w_unused = &{1'b0, w_kcnt, w_icnt, w_vcnt, w_k_lim, w_i_lim, w_v_lim};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= CS_INIT;
      r_sync_n <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_sync_n <= (w_state_nxt != CS_INIT);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (force_resync) begin
      w_state_nxt = CS_INIT;
    end else if (char_valid) begin
      case (r_state)
        CS_INIT:  if (w_comma_good && w_k_last) w_state_nxt = CS_DATA;
        CS_DATA:  if (char_err) w_state_nxt = CS_CHECK;
        CS_CHECK: begin
          if (char_err && w_i_last)        w_state_nxt = CS_INIT;
          else if (!char_err && w_v_last)  w_state_nxt = CS_DATA;
        end
        default:  w_state_nxt = CS_INIT;
      endcase
    end
  end

  always_comb begin
    sync_n    = r_sync_n;
    cgs_state = r_state;
    cgs_done  = (r_state != CS_INIT);
  end

`ifdef JESD_CGS_ERR_CNT_EN
  logic [15:0] w_err_cnt;
  logic        w_err_sat;
  logic        w_err_last;

  // Cleared only by reset; resync and INIT re-entry keep the history
  sat_counter #(.WIDTH(16), .LIMIT(16'hFFFF)) u_err_cnt (
    .clk(clk), .rst_n(rst_n),
    .inc(char_valid && char_err && (r_state != CS_INIT) && !w_err_sat),
    .clr(1'b0),
    .count(w_err_cnt), .at_limit(w_err_sat), .at_last(w_err_last)
  );

  logic w_unused_err;
  assign w_unused_err = w_err_last;
  assign err_cnt      = w_err_cnt;
`endif

endmodule

`default_nettype wire

// File: doc/jesd_rx_cgs_fsm.md
# jesd_rx_cgs_fsm

Receive-side JESD204B code group synchronization (CGS) controller for one lane. It consumes per-character output of the 8b/10b decoder (8-bit character, K flag, code-error flag) and searches for consecutive K28.5 comma characters. It drives the active-low SYNC~ request and tracks lane health through the CS_INIT / CS_CHECK / CS_DATA state machine. It sits directly downstream of the 8b/10b decoder and upstream of ILAS/frame alignment logic, which starts when `cgs_done` rises.

## Interface
Parameters:
- `K_CNT_TARGET`, 4: number of consecutive error-free K28.5 characters required to leave CS_INIT.
- `INV_LIMIT`, 3: number of invalid characters in CS_CHECK that forces a return to CS_INIT.
- `VALID_LIMIT`, 4: number of consecutive valid characters in CS_CHECK that returns the FSM to CS_DATA.

Ports:
- `clk`  in  1  single clock domain; one decoded character per cycle when `char_valid` is high.
- `rst_n`  in  1  asynchronous, active-low reset.
- `char_valid`  in  1  decoder output is valid this cycle.
- `char_data`  in  8  decoded character, with HGF in bits [7:5] and EDCBA in bits [4:0].
- `char_is_k`  in  1  the character is a control (K) character.
- `char_err`  in  1  disparity error or not-in-table error on this character.
- `force_resync`  in  1  synchronous request to restart CGS.
- `sync_n`  out  1  SYNC~ output; low means synchronization is requested.
- `cgs_state`  out  2  current state: CS_INIT=0, CS_CHECK=1, CS_DATA=2.
- `cgs_done`  out  1  high in CS_DATA and CS_CHECK.
- `err_cnt`  out  16  saturating code-error count. Present only with `JESD_CGS_ERR_CNT_EN`.

## Operation
- A character is "comma-good" when `char_valid && char_is_k && char_data==K28_5 && !char_err`. K28_5 is 8'b101_11100.
- CS_INIT:
  - On each valid character, `kcnt` increments if the character is comma-good, otherwise it clears to 0.
  - When the K_CNT_TARGET-th consecutive comma-good character is sampled, the FSM moves to CS_DATA and `sync_n` goes to 1.
- CS_DATA:
  - A valid character with `char_err` moves the FSM to CS_CHECK, with `icnt`=1 and `vcnt`=0.
  - Otherwise the FSM holds. Non-comma K characters and data characters are both valid here.
- CS_CHECK:
  - A valid character with `char_err` increments `icnt` and clears `vcnt`.
  - When `icnt` reaches INV_LIMIT, the FSM moves to CS_INIT with `sync_n`=0 and `kcnt`=0.
  - A valid character without error increments `vcnt`. When `vcnt` reaches VALID_LIMIT, the FSM moves to CS_DATA and clears `icnt`.
  - Valid characters do not clear `icnt`.
- `char_valid`=0: state and all counters hold.
- `force_resync`=1: the FSM goes to CS_INIT on the next edge and clears all counters. This has priority over every other transition, including a simultaneous 4th K28.5.
- Counters are sized by `$clog2` of their limit plus 1 and never exceed their limit.

## Timing
- Reset values: state CS_INIT, `sync_n`=0, `cgs_state`=0, `cgs_done`=0, `kcnt`/`icnt`/`vcnt`=0, `err_cnt`=0.
- All outputs are registered, with 1-cycle latency. The edge that samples the qualifying character updates state and outputs together, so `sync_n` rises in the cycle after the 4th K28.5 is presented.
- `cgs_done` equals `(state!=CS_INIT)`, decoded from the registered state with no extra delay.
- Reset asserted mid-operation immediately forces the reset values, including `sync_n`=0.
- After reset release, the first active edge already evaluates input.

## Configuration
- `JESD_CGS_ERR_CNT_EN` defined:
  - `err_cnt` port exists and increments on every valid character with `char_err` while in CS_DATA or CS_CHECK.
  - It saturates at 16'hFFFF.
  - It clears on reset only; it is not cleared by `force_resync` or by re-entering CS_INIT.
- Macro undefined: the `err_cnt` port and its register are absent. FSM behaviour is identical.

## Structure
- Shared package `jesd_rx_pkg`:
  - `cgs_state_t` enum {CS_INIT=2'd0, CS_CHECK=2'd1, CS_DATA=2'd2}.
  - Imports or re-declares K28_5 from the existing K-character constant package, so it is never hard-coded in RTL.
- The FSM is kept in one module. The saturating counters are a natural sub-module, `sat_counter` (parameterised width/limit, with inc, clr, and at_limit signals), instanced for `kcnt`, `icnt`, `vcnt` and `err_cnt`.

## Test plan
- Reset, then 4 consecutive K28.5 with `char_valid`=1 → `sync_n` 0→1 one cycle after the 4th character, `cgs_state`=2, `cgs_done`=1.
- K28.5 ×3, then D21.5 (8'hB5), then K28.5 ×4 → no exit on the first run; exit after the 8th character.
- In CS_DATA: 1 error, then 4 clean characters → CS_CHECK for 4 cycles, back to CS_DATA; `sync_n` stays 1 throughout.
- In CS_DATA: 3 errors interleaved with 2 clean characters → CS_INIT and `sync_n`=0 after the 3rd error; `err_cnt`=3 with the macro defined.
- `force_resync` asserted on the same cycle as the 4th K28.5, and `char_valid`=0 gaps inserted between commas → FSM stays in CS_INIT on the resync cycle; gaps do not break the K count.
- `rst_n` pulsed low while in CS_CHECK → outputs return immediately to reset values without waiting for `clk`.
